cp0_exc_ctrl: RTL and testbench

Exception/interrupt controller on the write side of the CP0 register block.
- Sits at the MEM/WB boundary. It reads the CP0 Status/Cause/EPC outputs together with the exception flags of the instruction in MEM.
- It decides whether to take an exception, interrupt or ERET, and sequences the resulting CP0 writes over the single CP0 write port.
- It stalls the pipeline during the sequence, then issues a one-cycle flush with the redirect PC.

---
 rtl/cp0_exc_ctrl_if.sv | 21 ++
 rtl/cp0_exc_ctrl.sv | 168 ++++++++++++++++
 tb/tb_cp0_exc_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_exc_ctrl_if.sv
// CP0 register-file link for the exception controller: read-back values
// plus the single CP0 write port.
interface cp0_exc_ctrl_if;
  logic [31:0] cp0_status_i;
  logic [31:0] cp0_cause_i;
  logic [31:0] cp0_epc_i;
  logic        cp0_we_o;
  logic [4:0]  cp0_waddr_o;
  logic [31:0] cp0_wdata_o;
  logic        cp0_exc_wr_o;

  modport master (
    input  cp0_status_i, cp0_cause_i, cp0_epc_i,
    output cp0_we_o, cp0_waddr_o, cp0_wdata_o, cp0_exc_wr_o
  );

  modport slave (
    output cp0_status_i, cp0_cause_i, cp0_epc_i,
    input  cp0_we_o, cp0_waddr_o, cp0_wdata_o, cp0_exc_wr_o
  );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// Exception/interrupt/ERET controller at MEM/WB: snapshots CP0 state on accept,
// sequences EPC/Cause/Status writes over one port, then flushes with a redirect PC.
module cp0_exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_0020,
  parameter logic [4:0]  STATUS_ADDR = 5'd12,
  parameter logic [4:0]  CAUSE_ADDR  = 5'd13,
  parameter logic [4:0]  EPC_ADDR    = 5'd14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_valid_i,
  input  logic [31:0]           excepttype_i,
  input  logic [31:0]           inst_addr_i,
  input  logic                  in_delayslot_i,
  cp0_exc_ctrl_if.master        cp0,
  output logic                  stall_req_o,
  output logic                  flush_o,
  output logic [31:0]           new_pc_o,
  output logic                  busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    WR_EPC,
    WR_CAUSE,
    WR_STATUS,
    REDIRECT
  } state_t;

  state_t      state_q, state_d;

  logic [31:0] st_q, ca_q, epc_q, pc_q;
  logic        ds_q, eret_q;
  logic [4:0]  code_q;

  logic [31:0] st_n, ca_n, epc_n, pc_n;
  logic        ds_n, eret_n;
  logic [4:0]  code_n;

  logic        irq, accept, eret_sel;
  logic [4:0]  code_sel;

  logic        we_d, exc_wr_d, flush_d;
  logic [4:0]  waddr_d;
  logic [31:0] wdata_d, new_pc_d;

  logic        unused_et;
  assign unused_et = ^{excepttype_i[31:13], excepttype_i[7:0]};

  always_comb begin
    irq = cp0.cp0_status_i[0] && !cp0.cp0_status_i[1] &&
          ((cp0.cp0_cause_i[15:8] & cp0.cp0_status_i[15:8]) != 8'h00);
    eret_sel = 1'b0;
    code_sel = 5'h00;
    if (irq)                  code_sel = 5'h00;
    else if (excepttype_i[8])  code_sel = 5'h08;
    else if (excepttype_i[9])  code_sel = 5'h0a;
    else if (excepttype_i[10]) code_sel = 5'h0d;
    else if (excepttype_i[11]) code_sel = 5'h0c;
    else                       eret_sel = 1'b1;
    accept = (state_q == IDLE) && mem_valid_i &&
             (irq || (excepttype_i[12:8] != 5'b0));
  end

  assign stall_req_o = accept || (state_q != IDLE);

  // Output registers are loaded from the next state and next snapshot so the
  // first write appears in the cycle right after the accept edge.
  always_comb begin
    st_n   = accept ? cp0.cp0_status_i : st_q;
    ca_n   = accept ? cp0.cp0_cause_i  : ca_q;
    epc_n  = accept ? cp0.cp0_epc_i    : epc_q;
    pc_n   = accept ? inst_addr_i      : pc_q;
    ds_n   = accept ? in_delayslot_i   : ds_q;
    eret_n = accept ? eret_sel         : eret_q;
    code_n = accept ? code_sel         : code_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (eret_n)     state_d = WR_STATUS;
          else if (st_n[1]) state_d = WR_CAUSE;
          else            state_d = WR_EPC;
        end
      end
      WR_EPC:    state_d = WR_CAUSE;
      WR_CAUSE:  state_d = WR_STATUS;
      WR_STATUS: state_d = REDIRECT;
      REDIRECT:  state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    we_d     = 1'b0;
    exc_wr_d = 1'b0;
    flush_d  = 1'b0;
    waddr_d  = cp0.cp0_waddr_o;
    wdata_d  = cp0.cp0_wdata_o;
    new_pc_d = new_pc_o;
    unique case (state_d)
      WR_EPC: begin
        we_d    = 1'b1;
        waddr_d = EPC_ADDR;
        wdata_d = ds_n ? (pc_n - 32'd4) : pc_n;
      end
      WR_CAUSE: begin
        we_d     = 1'b1;
        exc_wr_d = 1'b1;
        waddr_d  = CAUSE_ADDR;
        wdata_d  = {(st_n[1] ? ca_n[31] : ds_n), ca_n[30:7], code_n, ca_n[1:0]};
      end
      WR_STATUS: begin
        we_d    = 1'b1;
        waddr_d = STATUS_ADDR;
        wdata_d = eret_n ? (st_n & ~32'h2) : (st_n | 32'h2);
      end
      REDIRECT: begin
        flush_d  = 1'b1;
        new_pc_d = eret_n ? epc_n : EXC_VECTOR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q             <= '0;
      ca_q             <= '0;
      epc_q            <= '0;
      pc_q             <= '0;
      ds_q             <= 1'b0;
      eret_q           <= 1'b0;
      code_q           <= '0;
      cp0.cp0_we_o     <= 1'b0;
      cp0.cp0_exc_wr_o <= 1'b0;
      cp0.cp0_waddr_o  <= '0;
      cp0.cp0_wdata_o  <= '0;
      flush_o          <= 1'b0;
      new_pc_o         <= '0;
      busy_o           <= 1'b0;
    end else begin
      st_q             <= st_n;
      ca_q             <= ca_n;
      epc_q            <= epc_n;
      pc_q             <= pc_n;
      ds_q             <= ds_n;
      eret_q           <= eret_n;
      code_q           <= code_n;
      cp0.cp0_we_o     <= we_d;
      cp0.cp0_exc_wr_o <= exc_wr_d;
      cp0.cp0_waddr_o  <= waddr_d;
      cp0.cp0_wdata_o  <= wdata_d;
      flush_o          <= flush_d;
      new_pc_o         <= new_pc_d;
      busy_o           <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: queue-based behavioural model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_cp0_exc_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] et = '0, pc = '0;
  logic        ds = 1'b0;
  logic [31:0] st = '0, ca = '0, epc = '0;
  logic        stall_req, flush, busy;
  logic [31:0] new_pc;

  int total = 0;
  int bad = 0;

  cp0_exc_ctrl_if cp0_if ();
  assign cp0_if.cp0_status_i = st;
  assign cp0_if.cp0_cause_i  = ca;
  assign cp0_if.cp0_epc_i    = epc;

  cp0_exc_ctrl #(
    .EXC_VECTOR (32'h0000_0020),
    .STATUS_ADDR(5'd12),
    .CAUSE_ADDR (5'd13),
    .EPC_ADDR   (5'd14)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_valid_i   (mem_valid),
    .excepttype_i  (et),
    .inst_addr_i   (pc),
    .in_delayslot_i(ds),
    .cp0           (cp0_if),
    .stall_req_o   (stall_req),
    .flush_o       (flush),
    .new_pc_o      (new_pc),
    .busy_o        (busy)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct {
    bit        act, we, exc, fl;
    bit [4:0]  addr;
    bit [31:0] data, npc;
  } ent_t;

  ent_t cur;
  ent_t mq[$];

  function automatic bit irq_pend(logic [31:0] s, logic [31:0] c);
    return s[0] && !s[1] && ((c[15:8] & s[15:8]) != 8'h00);
  endfunction

  function automatic bit acc_now();
    return !cur.act && (mem_valid === 1'b1) && (irq_pend(st, ca) || et[12:8] != 5'b0);
  endfunction

  function automatic void push(bit we, bit exc, bit fl, bit [4:0] a, bit [31:0] d, bit [31:0] np);
    ent_t e;
    e.act = 1; e.we = we; e.exc = exc; e.fl = fl;
    e.addr = a; e.data = d; e.npc = np;
    mq.push_back(e);
  endfunction

  // Expected write/flush schedule for one taken event, straight from the rules.
  function automatic void plan();
    bit        irq, is_eret, bd;
    bit [31:0] code;
    bit [31:0] sw;
    irq = irq_pend(st, ca);
    is_eret = 0;
    if (irq)        code = 32'h00;
    else if (et[8]) code = 32'h08;
    else if (et[9]) code = 32'h0a;
    else if (et[10]) code = 32'h0d;
    else if (et[11]) code = 32'h0c;
    else begin code = 0; is_eret = 1; end
    if (is_eret) begin
      sw = st & ~32'h2;
      push(1, 0, 0, 12, sw, 0);
      push(0, 0, 1, 12, sw, epc);
    end else begin
      if (!st[1]) push(1, 0, 0, 14, ds ? pc - 32'd4 : pc, 0);
      bd = st[1] ? ca[31] : ds;
      push(1, 1, 0, 13, (ca & ~32'h8000_007c) | (32'(bd) << 31) | (code << 2), 0);
      sw = st | 32'h2;
      push(1, 0, 0, 12, sw, 0);
      push(0, 0, 1, 12, sw, 32'h20);
    end
  endfunction

  always @(posedge clk) begin
    if (rst === 1'b1) begin
      if (acc_now()) plan();
      if (mq.size() > 0) cur = mq.pop_front();
      else begin
        cur.act = 0; cur.we = 0; cur.exc = 0; cur.fl = 0;
      end
    end
  end

  always @(negedge rst) begin
    mq.delete();
    cur = '{default: 0};
  end

  always @(negedge clk) begin
    check("we",     cp0_if.cp0_we_o,     cur.we);
    check("exc_wr", cp0_if.cp0_exc_wr_o, cur.exc);
    check("waddr",  cp0_if.cp0_waddr_o,  cur.addr);
    check("wdata",  cp0_if.cp0_wdata_o,  cur.data);
    check("flush",  flush,               cur.fl);
    check("busy",   busy,                cur.act);
    check("stall",  stall_req,           cur.act | acc_now());
    if (!rst || cur.fl) check("new_pc", new_pc, cur.npc);
  end

  // ---------------- observation log ----------------
  logic [4:0]  wa[$];
  logic [31:0] wd[$];
  logic        wx[$];
  int          nflush = 0;

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (cp0_if.cp0_we_o) begin
        wa.push_back(cp0_if.cp0_waddr_o);
        wd.push_back(cp0_if.cp0_wdata_o);
        wx.push_back(cp0_if.cp0_exc_wr_o);
      end
      if (flush) nflush++;
    end
  end

  task automatic chk_wr(int i, logic [4:0] a, logic [31:0] d, logic x);
    if (i >= wa.size()) begin
      check("wr_missing", wa.size(), i + 1);
    end else begin
      check("wr_addr", wa[i], a);
      check("wr_data", wd[i], d);
      check("wr_exc",  wx[i], x);
    end
  endtask

  // Caller is 1 time unit after a posedge; returns likewise, in the cycle after REDIRECT.
  task automatic run_take(input logic [31:0] s, c, e, p, input logic d, input logic [31:0] t,
                          output int lat, output logic [31:0] np);
    wa.delete(); wd.delete(); wx.delete();
    st = s; ca = c; epc = e; pc = p; ds = d; et = t; mem_valid = 1'b1;
    @(posedge clk); #1;
    et = 32'h0000_0400;  // trap request while busy must be ignored
    lat = 0; np = '0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (flush) begin lat = n; np = new_pc; break; end
      @(posedge clk); #1;
    end
    #1 mem_valid = 1'b0; et = '0;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [31:0] np;

    @(negedge clk);
    check("rst_we",    cp0_if.cp0_we_o, 0);
    check("rst_busy",  busy, 0);
    check("rst_flush", flush, 0);
    #2 rst = 1'b1;
    @(posedge clk); #1;

    // Syscall
    run_take(32'h1000_ff01, 32'h0, 32'h0, 32'h0000_0100, 1'b0, 32'h100, lat, np);
    check("t1_lat", lat, 4);
    check("t1_pc", np, 32'h20);
    check("t1_nwr", wa.size(), 3);
    chk_wr(0, 14, 32'h0000_0100, 0);
    chk_wr(1, 13, 32'h0000_0020, 1);
    chk_wr(2, 12, 32'h1000_ff03, 0);

    // Delay-slot overflow with PC wrap
    run_take(32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h800, lat, np);
    check("t2_lat", lat, 4);
    chk_wr(0, 14, 32'hffff_fffc, 0);
    chk_wr(1, 13, 32'h8000_0030, 1);

    // Interrupt beats syscall
    run_take(32'h0000_8001, 32'h0000_8000, 32'h0, 32'h200, 1'b0, 32'h100, lat, np);
    chk_wr(1, 13, 32'h0000_8000, 1);
    chk_wr(2, 12, 32'h0000_8003, 0);

    // IE=0: syscall taken
    run_take(32'h0000_8000, 32'h0000_8000, 32'h0, 32'h200, 1'b0, 32'h100, lat, np);
    chk_wr(1, 13, 32'h0000_8020, 1);

    // Reserved instr over trap/overflow
    run_take(32'h0, 32'h0, 32'h0, 32'h400, 1'b0, 32'hE00, lat, np);
    chk_wr(1, 13, 32'h0000_0028, 1);

    // ERET
    run_take(32'h1000_0003, 32'h0, 32'h0000_0234, 32'h500, 1'b0, 32'h1000, lat, np);
    check("t4_lat", lat, 2);
    check("t4_pc", np, 32'h234);
    check("t4_nwr", wa.size(), 1);
    chk_wr(0, 12, 32'h1000_0001, 0);

    // EXL=1 trap
    run_take(32'h0000_0003, 32'h8000_0000, 32'h0, 32'h300, 1'b0, 32'h400, lat, np);
    check("t5_lat", lat, 3);
    check("t5_nwr", wa.size(), 2);
    chk_wr(0, 13, 32'h8000_0034, 1);
    chk_wr(1, 12, 32'h0000_0003, 0);

    // mem_valid=0 blocks everything
    st = 32'h0000_8001; ca = 32'h0000_8000; et = 32'h100; mem_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("nv_busy", busy, 0);
      check("nv_stall", stall_req, 0);
    end
    @(posedge clk); #1;

    // Reset during WR_CAUSE
    st = 32'h1000_ff01; ca = 32'h0; pc = 32'h100; ds = 1'b0; et = 32'h100; mem_valid = 1'b1;
    @(posedge clk); #1;
    mem_valid = 1'b0; et = '0;
    @(posedge clk); #1;
    check("r_pre_addr", cp0_if.cp0_waddr_o, 13);
    #1 rst = 1'b0;
    #1;
    check("r_we",    cp0_if.cp0_we_o, 0);
    check("r_exc",   cp0_if.cp0_exc_wr_o, 0);
    check("r_addr",  cp0_if.cp0_waddr_o, 0);
    check("r_data",  cp0_if.cp0_wdata_o, 0);
    check("r_stall", stall_req, 0);
    check("r_flush", flush, 0);
    check("r_busy",  busy, 0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    #1 rst = 1'b1;
    wa.delete(); wd.delete(); wx.delete(); nflush = 0;
    repeat (6) @(posedge clk);
    #1;
    check("r_nowr", wa.size(), 0);
    check("r_noflush", nflush, 0);
    run_take(32'h1000_ff01, 32'h0, 32'h0, 32'h0000_0100, 1'b0, 32'h100, lat, np);
    check("r2_lat", lat, 4);
    check("r2_nwr", wa.size(), 3);
    chk_wr(2, 12, 32'h1000_ff03, 0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
